// File: rtl/spi_word_fifo_receiver.sv
// SPI target that assembles WORD_WIDTH-bit words in any CPOL/CPHA mode, buffers them in a
// valid/ready FIFO and echoes each word back on MISO one word later, after a per-frame status word.
module spi_word_fifo_receiver #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CPOL        = 0,
  parameter int unsigned CPHA        = 1,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  spi_sclk_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_i,
  output logic                  spi_miso_o,
  output logic [WORD_WIDTH-1:0] word_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic                  frame_start_o,
  output logic                  frame_end_o,
  output logic [CNT_WIDTH-1:0]  frame_words_o,
  output logic                  overflow_o,
  input  logic                  clear_overflow_i
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;
  localparam int unsigned BIT_W  = $clog2(WORD_WIDTH);
  localparam int unsigned SS     = SYNC_STAGES;

  logic [SS-1:0]         sclk_sync_q, sclk_sync_d;
  logic [SS-1:0]         mosi_sync_q, mosi_sync_d;
  logic [SS-1:0]         cs_sync_q, cs_sync_d;
  logic                  sclk_dly_q, sclk_dly_d;
  logic                  cs_dly_q, cs_dly_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic                  miso_q, miso_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_end_q, frame_end_d;
  logic [CNT_WIDTH-1:0]  frame_words_q, frame_words_d;
  logic                  overflow_q, overflow_d;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]     count_q, count_d;

  logic                  sclk_sync, mosi_sync, cs_sync;
  logic                  sclk_rise, sclk_fall, sample_edge, shift_edge;
  logic                  cs_fall, cs_rise;
  logic                  push, push_ok, pop, full, drop;
  logic [WORD_WIDTH-1:0] push_data;

  assign sclk_sync   = sclk_sync_q[SS-1];
  assign mosi_sync   = mosi_sync_q[SS-1];
  assign cs_sync     = cs_sync_q[SS-1];
  assign sclk_rise   = sclk_sync & ~sclk_dly_q;
  assign sclk_fall   = ~sclk_sync & sclk_dly_q;
  assign sample_edge = ~cs_sync & ((CPOL == CPHA) ? sclk_rise : sclk_fall);
  assign shift_edge  = ~cs_sync & ((CPOL == CPHA) ? sclk_fall : sclk_rise);
  assign cs_fall     = ~cs_sync & cs_dly_q;
  assign cs_rise     = cs_sync & ~cs_dly_q;

  // Input synchronisers and the delayed copies used for edge detection
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SS-2:0], spi_sclk_i};
    mosi_sync_d = {mosi_sync_q[SS-2:0], spi_mosi_i};
    cs_sync_d   = {cs_sync_q[SS-2:0], spi_cs_i};
    sclk_dly_d  = sclk_sync;
    cs_dly_d    = cs_sync;
  end

  // Receive/transmit shifters, frame bookkeeping
  always_comb begin
    bit_cnt_d     = bit_cnt_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    miso_d        = miso_q;
    frame_words_d = frame_words_q;
    frame_start_d = cs_fall;
    frame_end_d   = cs_rise;
    push          = 1'b0;
    push_data     = {rx_sr_q[WORD_WIDTH-2:0], mosi_sync};

    if (cs_fall) begin
      bit_cnt_d             = '0;
      rx_sr_d               = '0;
      frame_words_d         = '0;
      tx_sr_d               = '0;
      tx_sr_d[WORD_WIDTH-1] = overflow_q;
      if (CPHA == 0) miso_d = overflow_q;
    end else if (cs_rise) begin
      bit_cnt_d = '0;
      rx_sr_d   = '0;
    end else begin
      if (sample_edge) begin
        rx_sr_d = push_data;
        if (bit_cnt_q == BIT_W'(WORD_WIDTH - 1)) begin
          bit_cnt_d = '0;
          push      = 1'b1;
          tx_sr_d   = push_data;
          if (frame_words_q != '1) frame_words_d = frame_words_q + CNT_WIDTH'(1);
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      // CPHA=0 presents a freshly loaded word's MSB unshifted at the word boundary
      if (shift_edge) begin
        if (CPHA == 0 && bit_cnt_q == '0) begin
          miso_d = tx_sr_q[WORD_WIDTH-1];
        end else if (CPHA == 0) begin
          tx_sr_d = {tx_sr_q[WORD_WIDTH-2:0], 1'b0};
          miso_d  = tx_sr_q[WORD_WIDTH-2];
        end else begin
          miso_d  = tx_sr_q[WORD_WIDTH-1];
          tx_sr_d = {tx_sr_q[WORD_WIDTH-2:0], 1'b0};
        end
      end
    end

    if (cs_sync) miso_d = 1'b0;
  end

  // Output FIFO; a pop frees the slot a simultaneous push into a full FIFO needs
  always_comb begin
    pop        = (count_q != '0) & word_ready_i;
    full       = (count_q == FCNT_W'(FIFO_DEPTH));
    drop       = push & full & ~pop;
    push_ok    = push & ~drop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = clear_overflow_i ? drop : (overflow_q | drop);

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + FCNT_W'(1);
      2'b01:   count_d = count_q - FCNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q   <= '0;
      mosi_sync_q   <= '0;
      cs_sync_q     <= '0;
      sclk_dly_q    <= 1'b0;
      cs_dly_q      <= 1'b0;
      bit_cnt_q     <= '0;
      rx_sr_q       <= '0;
      tx_sr_q       <= '0;
      miso_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_words_q <= '0;
      overflow_q    <= 1'b0;
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      cs_sync_q     <= cs_sync_d;
      sclk_dly_q    <= sclk_dly_d;
      cs_dly_q      <= cs_dly_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      miso_q        <= miso_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      frame_words_q <= frame_words_d;
      overflow_q    <= overflow_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  assign spi_miso_o    = miso_q;
  assign word_o        = mem_q[rd_ptr_q];
  assign word_valid_o  = (count_q != '0);
  assign frame_start_o = frame_start_q;
  assign frame_end_o   = frame_end_q;
  assign frame_words_o = frame_words_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_spi_word_fifo_receiver.sv
// Directed bench: four instances (one per CPOL/CPHA mode) share one SPI master; instance 1 is mode 1.
module tb_spi_word_fifo_receiver;

  localparam int unsigned H = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sclk_base, mosi, cs, ready, clr_ovf;
  logic [3:0] sclk_v, miso_v, valid_v, fs_v, fe_v, ovf_v;
  logic [7:0] word_v [4];
  logic [7:0] fw_v [4];
  logic [7:0] miso_word [4];
  logic [7:0] pop_q [$];
  int         checks = 0;
  int         failures = 0;
  int         fe_cnt = 0;
  int         fs_cnt = 0;
  int         fe_base;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      assign sclk_v[g] = (g >= 2) ? ~sclk_base : sclk_base;
      spi_word_fifo_receiver #(
        .WORD_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2),
        .CPOL(g / 2), .CPHA(g % 2), .CNT_WIDTH(8)
      ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .spi_sclk_i      (sclk_v[g]),
        .spi_mosi_i      (mosi),
        .spi_cs_i        (cs),
        .spi_miso_o      (miso_v[g]),
        .word_o          (word_v[g]),
        .word_valid_o    (valid_v[g]),
        .word_ready_i    (ready),
        .frame_start_o   (fs_v[g]),
        .frame_end_o     (fe_v[g]),
        .frame_words_o   (fw_v[g]),
        .overflow_o      (ovf_v[g]),
        .clear_overflow_i(clr_ovf)
      );
    end
  endgenerate

  // Record every word popped from the mode-1 instance
  always @(posedge clk) begin
    if (valid_v[1] && ready) pop_q.push_back(word_v[1]);
    if (fe_v[1]) fe_cnt++;
    if (fs_v[1]) fs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master drives one bit per 3H cycles; CPHA=0 targets are read at the leading toggle, CPHA=1 at the trailing one
  task automatic send_bits(input logic [7:0] w, input int n, input bit rdy_last);
    for (int k = 0; k < 4; k++) miso_word[k] = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = w[7-i];
      cycles(H);
      for (int k = 0; k < 4; k += 2) miso_word[k] = {miso_word[k][6:0], miso_v[k]};
      sclk_base = ~sclk_base;
      cycles(H);
      for (int k = 1; k < 4; k += 2) miso_word[k] = {miso_word[k][6:0], miso_v[k]};
      sclk_base = ~sclk_base;
      if (rdy_last && i == n - 1) begin
        cycles(2);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
        cycles(H - 3);
      end else begin
        cycles(H);
      end
    end
  endtask

  task automatic send_word(input logic [7:0] w);
    send_bits(w, 8, 1'b0);
  endtask

  task automatic frame_begin();
    cs = 1'b0;
    cycles(2 * H);
  endtask

  task automatic frame_finish();
    cycles(H);
    cs = 1'b1;
    cycles(2 * H);
  endtask

  initial begin
    rst_n = 1'b0; sclk_base = 1'b0; mosi = 1'b0; cs = 1'b1; ready = 1'b0; clr_ovf = 1'b0;
    cycles(3);
    chk("rst_valid", valid_v[1], 0);
    chk("rst_word", word_v[1], 0);
    chk("rst_ovf", ovf_v[1], 0);
    chk("rst_miso", miso_v[1], 0);
    chk("rst_fw", fw_v[1], 0);
    rst_n = 1'b1;
    cycles(10);

    // Two words in one frame, consumer always ready
    ready = 1'b1;
    frame_begin();
    send_word(8'hA5);
    chk("t1_miso_status", miso_word[1], 8'h00);
    send_word(8'h3C);
    chk("t1_miso_echo", miso_word[1], 8'hA5);
    frame_finish();
    chk("t1_pop_count", pop_q.size(), 2);
    chk("t1_pop0", pop_q[0], 8'hA5);
    chk("t1_pop1", pop_q[1], 8'h3C);
    chk("t1_frame_words", fw_v[1], 2);
    chk("t1_frame_start", fs_cnt, 1);
    ready = 1'b0;
    pop_q.delete();

    // Five words into a four-entry FIFO with no consumer
    frame_begin();
    send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44); send_word(8'h55);
    frame_finish();
    chk("t3_valid", valid_v[1], 1);
    chk("t3_head", word_v[1], 8'h11);
    chk("t3_overflow", ovf_v[1], 1);
    chk("t3_frame_words", fw_v[1], 5);
    ready = 1'b1;
    cycles(8);
    ready = 1'b0;
    chk("t3_pop_count", pop_q.size(), 4);
    chk("t3_pop0", pop_q[0], 8'h11);
    chk("t3_pop3", pop_q[3], 8'h44);
    chk("t3_empty", valid_v[1], 0);
    pop_q.delete();

    // All four modes: status 0x80 then 0x81 received
    frame_begin();
    send_word(8'h81);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_status_m%0d", k), miso_word[k], 8'h80);
      chk($sformatf("t2_word_m%0d", k), word_v[k], 8'h81);
      chk($sformatf("t2_valid_m%0d", k), valid_v[k], 1);
    end
    frame_finish();
    chk("t3_ovf_held", ovf_v[1], 1);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    cycles(1);
    chk("t3_ovf_cleared", ovf_v[1], 0);
    ready = 1'b1;
    cycles(2);
    ready = 1'b0;
    pop_q.delete();

    // Full FIFO popped in the very cycle the fifth word is pushed
    frame_begin();
    send_word(8'h01); send_word(8'h02); send_word(8'h03); send_word(8'h04);
    send_bits(8'h05, 8, 1'b1);
    frame_finish();
    chk("t4_no_overflow", ovf_v[1], 0);
    chk("t4_pop_count", pop_q.size(), 1);
    chk("t4_pop0", pop_q[0], 8'h01);
    chk("t4_head", word_v[1], 8'h02);
    ready = 1'b1;
    cycles(8);
    ready = 1'b0;
    chk("t4_drain_count", pop_q.size(), 5);
    chk("t4_pop1", pop_q[1], 8'h02);
    chk("t4_pop4", pop_q[4], 8'h05);
    pop_q.delete();

    // Aborted partial word, then a complete frame
    ready = 1'b1;
    frame_begin();
    send_bits(8'hB7, 5, 1'b0);
    frame_finish();
    chk("t5_abort_pops", pop_q.size(), 0);
    chk("t5_abort_fw", fw_v[1], 0);
    fe_base = fe_cnt;
    frame_begin();
    send_word(8'h5A);
    frame_finish();
    chk("t5_frame_end", fe_cnt - fe_base, 1);
    chk("t5_pop_count", pop_q.size(), 1);
    chk("t5_pop0", pop_q[0], 8'h5A);
    chk("t5_frame_words", fw_v[1], 1);
    ready = 1'b0;
    pop_q.delete();

    // Reset in the middle of a word with data queued
    frame_begin();
    send_word(8'h77);
    send_bits(8'hFF, 3, 1'b0);
    chk("t6_pre_valid", valid_v[1], 1);
    chk("t6_pre_fw", fw_v[1], 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", valid_v[1], 0);
    chk("t6_rst_word", word_v[1], 0);
    chk("t6_rst_fw", fw_v[1], 0);
    chk("t6_rst_miso", miso_v[1], 0);
    chk("t6_rst_ovf", ovf_v[1], 0);
    cs = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(10);
    ready = 1'b1;
    frame_begin();
    send_word(8'hC3);
    chk("t6_miso_status", miso_word[1], 8'h00);
    frame_finish();
    chk("t6_pop_count", pop_q.size(), 1);
    chk("t6_pop0", pop_q[0], 8'hC3);
    chk("t6_frame_words", fw_v[1], 1);
    ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
